// File: rtl/snd_pkg.sv
// Shared types for the sound path: sample word, bridge polarity mode, frame length helper.
package snd_pkg;

   localparam int unsigned SND_N = 9;

   typedef logic [SND_N-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POS  = 2'd1,
      NEG  = 2'd2
   } mode_t;

   function automatic int unsigned frame_len(input int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_bridge_driver_if.sv
// Sample-in / gate-out bundle between the sine generator side and the bridge driver.
interface pwm_bridge_driver_if #(
   parameter int unsigned N = 9
);
   logic         enable;
   logic [N-1:0] pos_in;
   logic [N-1:0] neg_in;
   logic         pwm_p;
   logic         pwm_n;
   logic         sample_tick;
   logic         frame_start;
   logic         fault;

   modport master (
      output enable, pos_in, neg_in,
      input  pwm_p, pwm_n, sample_tick, frame_start, fault
   );

   modport slave (
      input  enable, pos_in, neg_in,
      output pwm_p, pwm_n, sample_tick, frame_start, fault
   );
endinterface

// File: rtl/pwm_frame_counter.sv
// PWM frame counter: counts 0..P-1 while enabled, held at 0 otherwise; emits frame/sample strobes.
module pwm_frame_counter
   import snd_pkg::*;
#(
   parameter int unsigned N = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_enable,
   output logic [N-1:0] o_cnt,
   output logic         o_frame_start,
   output logic         o_sample_tick
);

   localparam logic [N-1:0] LAST = N'(frame_len(N) - 1);
   localparam logic [N-1:0] ONE  = N'(1);

   logic [N-1:0] r_cnt;
   logic         r_frame_start;
   logic         r_sample_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt         <= '0;
         r_frame_start <= 1'b0;
         r_sample_tick <= 1'b0;
      end else if (!i_enable) begin
         r_cnt         <= '0;
         r_frame_start <= 1'b0;
         r_sample_tick <= 1'b0;
      end else begin
         r_cnt         <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
         r_frame_start <= (r_cnt == '0);
         r_sample_tick <= (r_cnt == ONE);
      end
   end

   assign o_cnt         = r_cnt;
   assign o_frame_start = r_frame_start;
   assign o_sample_tick = r_sample_tick;

endmodule

// File: rtl/pwm_bridge_driver.sv
// H-bridge PWM driver: latches polarity/duty per frame, inserts dead-time on polarity flips.
module pwm_bridge_driver
   import snd_pkg::*;
#(
   parameter int unsigned N    = 9,
   parameter int unsigned DEAD = 4
) (
   input logic                 clk,
   input logic                 reset,
   pwm_bridge_driver_if.slave  bus
);

   localparam logic [N-1:0] DEAD_V = N'(DEAD);

   logic [N-1:0] w_cnt;
   logic         w_frame_start;
   logic         w_sample_tick;

   mode_t        r_mode, w_mode_nxt;
   logic [N-1:0] r_duty, w_duty_nxt;
   logic         r_dead, w_dead_nxt;
   logic         r_fault, w_fault_nxt;
   logic         w_latch;
   logic         w_pos_nz, w_neg_nz;
   logic         w_gate;
   logic         w_pwm_p_d, w_pwm_n_d;
   logic         r_pwm_p, r_pwm_n;

   pwm_frame_counter #(
      .N (N)
   ) u_frame_counter (
      .clk           (clk),
      .reset         (reset),
      .i_enable      (bus.enable),
      .o_cnt         (w_cnt),
      .o_frame_start (w_frame_start),
      .o_sample_tick (w_sample_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode  <= IDLE;
         r_duty  <= '0;
         r_dead  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_mode  <= w_mode_nxt;
         r_duty  <= w_duty_nxt;
         r_dead  <= w_dead_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   always_comb begin
      w_latch     = bus.enable && (w_cnt == '0);
      w_pos_nz    = |bus.pos_in;
      w_neg_nz    = |bus.neg_in;
      w_mode_nxt  = r_mode;
      w_duty_nxt  = r_duty;
      w_dead_nxt  = r_dead;
      w_fault_nxt = r_fault;
      if (!bus.enable) begin
         w_mode_nxt = IDLE;
         w_dead_nxt = 1'b0;
      end else if (w_latch) begin
         if (w_pos_nz && !w_neg_nz) begin
            w_mode_nxt = POS;
            w_duty_nxt = bus.pos_in;
         end else if (w_neg_nz && !w_pos_nz) begin
            w_mode_nxt = NEG;
            w_duty_nxt = bus.neg_in;
         end else begin
            w_mode_nxt = IDLE;
            if (w_pos_nz && w_neg_nz) begin
               w_fault_nxt = 1'b1;
            end
         end
         w_dead_nxt = ((w_mode_nxt == POS) && (r_mode == NEG)) ||
                      ((w_mode_nxt == NEG) && (r_mode == POS));
      end
   end

   // *_nxt equal the registers outside a latch point, so the latch cycle sees fresh values.
   always_comb begin
      w_gate    = (w_cnt < w_duty_nxt) && !(w_dead_nxt && (w_cnt < DEAD_V));
      w_pwm_p_d = bus.enable && (w_mode_nxt == POS) && w_gate;
      w_pwm_n_d = bus.enable && (w_mode_nxt == NEG) && w_gate;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm_p <= 1'b0;
         r_pwm_n <= 1'b0;
      end else begin
         r_pwm_p <= w_pwm_p_d;
         r_pwm_n <= w_pwm_n_d;
      end
   end

   assign bus.pwm_p       = r_pwm_p;
   assign bus.pwm_n       = r_pwm_n;
   assign bus.frame_start = w_frame_start;
   assign bus.sample_tick = w_sample_tick;
   assign bus.fault       = r_fault;

endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Scoreboard bench: frame-level reference model predicts each cycle's outputs, monitor compares.
module tb_pwm_bridge_driver;

   localparam int N    = 9;
   localparam int DEAD = 4;
   localparam int P    = (1 << N) - 1;

   logic clk = 1'b0;
   logic reset;

   pwm_bridge_driver_if #(.N(N)) bus ();

   pwm_bridge_driver #(
      .N    (N),
      .DEAD (DEAD)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // expected {pwm_p, pwm_n, sample_tick, frame_start, fault}
   logic [4:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: 0=idle, 1=positive, 2=negative
   int m_cnt   = 0;
   int m_mode  = 0;
   int m_duty  = 0;
   bit m_dead  = 0;
   bit m_fault = 0;

   task automatic model_and_push();
      logic [4:0] e;
      int pos, neg, newm;
      bit g;
      pos = int'(bus.pos_in);
      neg = int'(bus.neg_in);
      if (reset) begin
         e = 5'b0;
         m_cnt = 0; m_mode = 0; m_duty = 0; m_dead = 0; m_fault = 0;
      end else if (!bus.enable) begin
         e = {4'b0, m_fault};
         m_cnt = 0; m_mode = 0; m_dead = 0;
      end else begin
         if (m_cnt == 0) begin
            if (pos != 0 && neg == 0)      newm = 1;
            else if (neg != 0 && pos == 0) newm = 2;
            else                           newm = 0;
            if (pos != 0 && neg != 0) m_fault = 1;
            m_dead = (newm == 1 && m_mode == 2) || (newm == 2 && m_mode == 1);
            if (newm == 1) m_duty = pos;
            if (newm == 2) m_duty = neg;
            m_mode = newm;
         end
         g = (m_cnt < m_duty) && !(m_dead && m_cnt < DEAD);
         e = {(m_mode == 1) && g, (m_mode == 2) && g, m_cnt == 1, m_cnt == 0, m_fault};
         m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      model_and_push();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic frames(input int pos, input int neg, input int nf);
      bus.pos_in = N'(pos);
      bus.neg_in = N'(neg);
      run(nf * P);
   endtask

   // monitor
   initial begin
      logic [4:0] got, e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         got = {bus.pwm_p, bus.pwm_n, bus.sample_tick, bus.frame_start, bus.fault};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL outputs cyc=%0d got p/n/st/fs/fault=%b required %b", cyc, got, e);
            end
            n_cmp++;
            if ((bus.pwm_p & bus.pwm_n) !== 1'b0) begin
               n_bad++;
               $display("FAIL shoot_through cyc=%0d got p&n=%b required 0", cyc, bus.pwm_p & bus.pwm_n);
            end
         end
      end
   end

   initial begin
      int kind, hold;
      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.pos_in = '0;
      bus.neg_in = '0;
      @(negedge clk);
      run(3);
      reset = 1'b0;
      run(2);

      bus.enable = 1'b1;
      frames(256, 0, 2);
      frames(300, 0, 1);
      frames(0, 300, 1);
      frames(511, 0, 1);
      frames(0, 0, 1);
      frames(0, 300, 1);
      frames(5, 5, 1);
      frames(200, 0, 1);
      frames(0, 150, 1);

      bus.pos_in = N'(400);
      bus.neg_in = '0;
      run(100);
      bus.enable = 1'b0;
      run(5);
      bus.enable = 1'b1;
      frames(0, 400, 1);

      run(50);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run(3);

      for (int it = 0; it < 50; it++) begin
         kind = $urandom_range(0, 19);
         if (kind < 8) begin
            bus.pos_in = N'($urandom_range(1, P));
            bus.neg_in = '0;
         end else if (kind < 16) begin
            bus.pos_in = '0;
            bus.neg_in = N'($urandom_range(1, P));
         end else if (kind < 18) begin
            bus.pos_in = '0;
            bus.neg_in = '0;
         end else begin
            bus.pos_in = N'($urandom_range(1, P));
            bus.neg_in = N'($urandom_range(1, P));
         end
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P) : P;
         run(hold);
         if ($urandom_range(0, 9) == 0) begin
            bus.enable = 1'b0;
            run($urandom_range(1, 6));
            bus.enable = 1'b1;
         end
         if ($urandom_range(0, 24) == 0) begin
            reset = 1'b1;
            run($urandom_range(1, 3));
            reset = 1'b0;
         end
      end

      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
